time_msg_encoder: RTL and testbench

TIME_MSG_ENCODER -- requirements
Module: time_msg_encoder

---
 rtl/time_msg_encoder_pkg.sv | 24 ++
 rtl/bcd_to_ascii.sv | 17 +
 rtl/time_msg_encoder.sv | 166 ++++++++++++++++
 tb/tb_time_msg_encoder.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_msg_encoder_pkg.sv
// Shared constants, FSM state type and message lengths for the time message encoder.
package time_msg_encoder_pkg;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ESC   = 8'h1B;
    localparam logic [7:0] ASCII_AT    = 8'h40;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;

    localparam int unsigned MSG_LEN_BASE  = 10;
    localparam int unsigned MSG_LEN_ALARM = 12;

    localparam logic [3:0] LAST_IDX_BASE  = 4'(MSG_LEN_BASE - 1);
    localparam logic [3:0] LAST_IDX_ALARM = 4'(MSG_LEN_ALARM - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

endpackage

// File: rtl/bcd_to_ascii.sv
// Maps one BCD nibble to its ASCII digit; non-decimal nibbles become '?'.
module bcd_to_ascii
    import time_msg_encoder_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble <= 4'd9) begin
            ascii = ASCII_ZERO + {4'h0, nibble};
        end else begin
            ascii = ASCII_QMARK;
        end
    end

endmodule

// File: rtl/time_msg_encoder.sv
// Serialises a captured BCD time as "hh:mm:ss\r\n" over a valid/ready byte stream.
// Define TIME_MSG_ALARM_EN to append " @" before CR/LF when the captured alarm flag is set.
module time_msg_encoder
    import time_msg_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] time_bcd,
    input  logic        alarm_flag,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        busy,
    output logic        done
);

    state_e      state_q, state_d;
    logic [23:0] time_q, time_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        handshake;
    logic        last_byte;
    logic        start_accept;
    logic [3:0]  last_idx;
    logic [7:0]  digit_ascii [6];
    logic [7:0]  byte_d;

`ifdef TIME_MSG_ALARM_EN
    logic alarm_q, alarm_d;

    assign last_idx = alarm_q ? LAST_IDX_ALARM : LAST_IDX_BASE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end
`else
    logic alarm_unused;

    assign alarm_unused = alarm_flag;
    assign last_idx     = LAST_IDX_BASE;
`endif

    assign handshake    = tx_valid_q & tx_ready;
    assign last_byte    = handshake && (idx_q == last_idx);
    assign start_accept = start && (state_q == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)     state_d = ST_SEND;
            ST_SEND: if (last_byte) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Capture and index update; the byte mux below looks at the next-cycle values.
    always_comb begin
        time_d = time_q;
        idx_d  = idx_q;
`ifdef TIME_MSG_ALARM_EN
        alarm_d = alarm_q;
`endif
        if (start_accept) begin
            time_d = time_bcd;
            idx_d  = 4'd0;
`ifdef TIME_MSG_ALARM_EN
            alarm_d = alarm_flag;
`endif
        end else if (handshake && !last_byte) begin
            idx_d = idx_q + 4'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_digit
            bcd_to_ascii u_bcd_to_ascii (
                .nibble (time_d[23 - 4*gi -: 4]),
                .ascii  (digit_ascii[gi])
            );
        end
    endgenerate

    always_comb begin
        byte_d = 8'h00;
        case (idx_d)
            4'd0:  byte_d = digit_ascii[0];
            4'd1:  byte_d = digit_ascii[1];
            4'd2:  byte_d = ASCII_COLON;
            4'd3:  byte_d = digit_ascii[2];
            4'd4:  byte_d = digit_ascii[3];
            4'd5:  byte_d = ASCII_COLON;
            4'd6:  byte_d = digit_ascii[4];
            4'd7:  byte_d = digit_ascii[5];
`ifdef TIME_MSG_ALARM_EN
            4'd8:  byte_d = alarm_d ? ASCII_SPACE : ASCII_CR;
            4'd9:  byte_d = alarm_d ? ASCII_AT : ASCII_LF;
            4'd10: byte_d = ASCII_CR;
            4'd11: byte_d = ASCII_LF;
`else
            4'd8:  byte_d = ASCII_CR;
            4'd9:  byte_d = ASCII_LF;
`endif
            default: byte_d = 8'h00;
        endcase
    end

    always_comb begin
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tx_data_d  = tx_data_q;
        if (start_accept) begin
            tx_valid_d = 1'b1;
            busy_d     = 1'b1;
            tx_data_d  = byte_d;
        end else if (last_byte) begin
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            tx_data_d  = 8'h00;
        end else if (handshake) begin
            tx_data_d  = byte_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_q     <= '0;
            idx_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            time_q     <= time_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_time_msg_encoder.sv
// Randomised self-checking bench for time_msg_encoder against a byte-list reference model.
module tb_time_msg_encoder;

    typedef logic [7:0] byte_q_t [$];

    localparam int MAX_CYCLES = 400;
    localparam bit ALARM_EN =
`ifdef TIME_MSG_ALARM_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] time_bcd = '0;
    logic        alarm_flag = 1'b0;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    time_msg_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .time_bcd   (time_bcd),
        .alarm_flag (alarm_flag),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish before limit");
        $fatal(1, "watchdog");
    end

    // Expected message: digits as ASCII ('?' for 10-15), separators, optional " @", CR LF.
    function automatic byte_q_t model_msg(input logic [23:0] t, input logic alarm);
        byte_q_t     m;
        logic [7:0]  d [6];
        for (int i = 0; i < 6; i++) begin
            int nib;
            nib  = int'((t >> (20 - 4*i)) & 24'hF);
            d[i] = (nib < 10) ? 8'(8'h30 + nib) : 8'h3F;
        end
        m = {d[0], d[1], 8'h3A, d[2], d[3], 8'h3A, d[4], d[5]};
        if (ALARM_EN && alarm) begin
            m.push_back(8'h20);
            m.push_back(8'h40);
        end
        m.push_back(8'h0D);
        m.push_back(8'h0A);
        return m;
    endfunction

    function automatic logic [23:0] rand_time(input bit allow_bad);
        logic [23:0] t;
        for (int i = 0; i < 6; i++) begin
            int nib;
            nib = (allow_bad && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                                          : int'($urandom_range(0, 9));
            t[23 - 4*i -: 4] = 4'(nib);
        end
        return t;
    endfunction

    // Called at a falling edge; leaves the bench one cycle later with start low.
    task automatic pulse_start(input logic [23:0] t, input logic a);
        time_bcd   = t;
        alarm_flag = a;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        time_bcd   = 24'($urandom);
        alarm_flag = 1'($urandom);
    endtask

    // Drives tx_ready (0: always, 1: 1-high/3-low, else random) and records accepted bytes until done.
    task automatic collect(input int mode, output byte_q_t got, output int cycles,
                           output int bad_hold, output bit timed_out);
        logic       prev_stall;
        logic [7:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        got        = {};
        bad_hold   = 0;
        cycles     = MAX_CYCLES;
        timed_out  = 1'b1;
        for (int cyc = 0; cyc < MAX_CYCLES; cyc++) begin
            if (done === 1'b1) begin
                cycles    = cyc;
                timed_out = 1'b0;
                break;
            end
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (cyc % 4 == 0);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) bad_hold++;
            if (tx_valid !== 1'b1 && tx_data !== 8'h00) bad_hold++;
            if (tx_valid === 1'b1 && tx_ready) got.push_back(tx_data);
            prev_stall = (tx_valid === 1'b1) && !tx_ready;
            prev_data  = tx_data;
            @(negedge clk);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_reset;
        start    = 1'b1;
        time_bcd = 24'h123456;
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: valid=%b busy=%b done=%b data=%02h, required 0 0 0 00",
                     tx_valid, busy, done, tx_data);
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: valid=%b busy=%b, required 0 0", tx_valid, busy);
        end
        $display("reset: outputs idle after reset");
    endtask

    task automatic test_full_rate;
        byte_q_t got, exp;
        int cycles, bad_hold;
        bit timed_out;
        exp = model_msg(24'h123045, 1'b0);
        pulse_start(24'h123045, 1'b0);
        checks++;
        if (tx_valid !== 1'b1 || busy !== 1'b1 || tx_data !== exp[0]) begin
            errors++;
            $display("FAIL first_byte_latency: valid=%b busy=%b data=%02h, required 1 1 %02h",
                     tx_valid, busy, tx_data, exp[0]);
        end
        collect(0, got, cycles, bad_hold, timed_out);
        $display("msg time=123045 alarm=0 bytes=%0d cycles=%0d", got.size(), cycles);
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL full_rate_timeout: done not seen, required within %0d cycles", MAX_CYCLES);
        end
        checks++;
        if (cycles != 10) begin
            errors++;
            $display("FAIL full_rate_cycles: got %0d, required 10", cycles);
        end
        checks++;
        if (got.size() != exp.size()) begin
            errors++;
            $display("FAIL full_rate_len: got %0d, required %0d", got.size(), exp.size());
        end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL full_rate_byte%0d: got %02h, required %02h", i, got[i], exp[i]);
            end
        end
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL done_cycle_outputs: valid=%b busy=%b data=%02h, required 0 0 00",
                     tx_valid, busy, tx_data);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_single_pulse: done=%b one cycle later, required 0", done);
        end
    endtask

    task automatic test_stall;
        byte_q_t got, exp;
        int cycles, bad_hold;
        bit timed_out;
        exp = model_msg(24'h123045, 1'b0);
        pulse_start(24'h123045, 1'b0);
        collect(1, got, cycles, bad_hold, timed_out);
        $display("msg time=123045 alarm=0 bytes=%0d cycles=%0d (stalled)", got.size(), cycles);
        checks++;
        if (timed_out || bad_hold != 0) begin
            errors++;
            $display("FAIL stall_hold: timeout=%0d hold_violations=%0d, required 0 0", timed_out, bad_hold);
        end
        checks++;
        if (got.size() != exp.size()) begin
            errors++;
            $display("FAIL stall_len: got %0d, required %0d", got.size(), exp.size());
        end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL stall_byte%0d: got %02h, required %02h", i, got[i], exp[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_bad_digit;
        byte_q_t got, exp;
        int cycles, bad_hold;
        bit timed_out;
        exp = model_msg(24'h2A5959, 1'b0);
        pulse_start(24'h2A5959, 1'b0);
        collect(2, got, cycles, bad_hold, timed_out);
        $display("msg time=2A5959 alarm=0 bytes=%0d cycles=%0d", got.size(), cycles);
        checks++;
        if (timed_out || bad_hold != 0 || got.size() != exp.size()) begin
            errors++;
            $display("FAIL bad_digit_msg: timeout=%0d hold_violations=%0d len=%0d, required 0 0 %0d",
                     timed_out, bad_hold, got.size(), exp.size());
        end
        checks++;
        if (got.size() < 2 || got[1] !== 8'h3F) begin
            errors++;
            $display("FAIL bad_digit_qmark: second byte %02h, required 3f", (got.size() < 2) ? 8'h00 : got[1]);
        end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL bad_digit_byte%0d: got %02h, required %02h", i, got[i], exp[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_alarm;
        byte_q_t got, exp;
        int cycles, bad_hold;
        bit timed_out;
        exp = model_msg(24'h070000, 1'b1);
        pulse_start(24'h070000, 1'b1);
        collect(0, got, cycles, bad_hold, timed_out);
        $display("msg time=070000 alarm=1 bytes=%0d cycles=%0d", got.size(), cycles);
        checks++;
        if (timed_out || got.size() != exp.size() || cycles != exp.size()) begin
            errors++;
            $display("FAIL alarm_len: timeout=%0d len=%0d cycles=%0d, required 0 %0d %0d",
                     timed_out, got.size(), cycles, exp.size(), exp.size());
        end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL alarm_byte%0d: got %02h, required %02h", i, got[i], exp[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        for (int n = 0; n < 10; n++) begin
            byte_q_t got, exp;
            int cycles, bad_hold;
            bit timed_out;
            logic [23:0] t;
            logic a;
            t   = rand_time(1'b1);
            a   = 1'($urandom);
            exp = model_msg(t, a);
            pulse_start(t, a);
            collect(2, got, cycles, bad_hold, timed_out);
            $display("msg time=%06h alarm=%0d bytes=%0d cycles=%0d", t, a, got.size(), cycles);
            checks++;
            if (timed_out || bad_hold != 0 || got.size() != exp.size()) begin
                errors++;
                $display("FAIL random%0d_msg: timeout=%0d hold_violations=%0d len=%0d, required 0 0 %0d",
                         n, timed_out, bad_hold, got.size(), exp.size());
            end
            for (int i = 0; i < got.size() && i < exp.size(); i++) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL random%0d_byte%0d: got %02h, required %02h", n, i, got[i], exp[i]);
                end
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        byte_q_t got, exp_a, exp_b;
        logic [23:0] tb_b;
        int k, cycles, bad_hold;
        bit timed_out;
        exp_a = model_msg(24'h102030, 1'b0);
        tb_b  = rand_time(1'b0);
        exp_b = model_msg(tb_b, 1'b0);
        tx_ready = 1'b1;
        pulse_start(24'h102030, 1'b0);
        got = {};
        for (k = 0; k < MAX_CYCLES; k++) begin
            if (done === 1'b1) break;
            if (k == 4) begin
                start      = 1'b1;
                time_bcd   = 24'h999999;
                alarm_flag = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (tx_valid === 1'b1) got.push_back(tx_data);
            @(negedge clk);
        end
        $display("msg time=102030 alarm=0 bytes=%0d cycles=%0d (start while busy)", got.size(), k);
        checks++;
        if (k != 10 || got.size() != exp_a.size()) begin
            errors++;
            $display("FAIL busy_start_ignored: cycles=%0d len=%0d, required 10 %0d", k, got.size(), exp_a.size());
        end
        for (int i = 0; i < got.size() && i < exp_a.size(); i++) begin
            checks++;
            if (got[i] !== exp_a[i]) begin
                errors++;
                $display("FAIL busy_start_byte%0d: got %02h, required %02h", i, got[i], exp_a[i]);
            end
        end
        tx_ready = 1'b0;
        pulse_start(tb_b, 1'b0);
        checks++;
        if (tx_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || tx_data !== exp_b[0]) begin
            errors++;
            $display("FAIL done_cycle_start: valid=%b busy=%b done=%b data=%02h, required 1 1 0 %02h",
                     tx_valid, busy, done, tx_data, exp_b[0]);
        end
        collect(0, got, cycles, bad_hold, timed_out);
        $display("msg time=%06h alarm=0 bytes=%0d cycles=%0d (started in done cycle)", tb_b, got.size(), cycles);
        checks++;
        if (timed_out || got.size() != exp_b.size()) begin
            errors++;
            $display("FAIL done_start_len: timeout=%0d len=%0d, required 0 %0d", timed_out, got.size(), exp_b.size());
        end
        for (int i = 0; i < got.size() && i < exp_b.size(); i++) begin
            checks++;
            if (got[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL done_start_byte%0d: got %02h, required %02h", i, got[i], exp_b[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        byte_q_t got, exp;
        int cycles, bad_hold;
        bit timed_out;
        int idle_bad;
        exp = model_msg(24'h235958, 1'b0);
        tx_ready = 1'b1;
        pulse_start(24'h235958, 1'b0);
        repeat (6) @(negedge clk);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== exp[6]) begin
            errors++;
            $display("FAIL reset_mid_setup: valid=%b data=%02h, required 1 %02h", tx_valid, tx_data, exp[6]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_async: valid=%b busy=%b done=%b data=%02h, required 0 0 0 00",
                     tx_valid, busy, done, tx_data);
        end
        start    = 1'b1;
        time_bcd = 24'h111111;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        idle_bad = 0;
        for (int c = 0; c < 6; c++) begin
            if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) idle_bad++;
            @(negedge clk);
        end
        $display("reset mid-message at byte 6, idle cycles checked after release=6");
        checks++;
        if (idle_bad != 0) begin
            errors++;
            $display("FAIL reset_no_resume: active cycles=%0d, required 0", idle_bad);
        end
        exp = model_msg(24'h000102, 1'b0);
        pulse_start(24'h000102, 1'b0);
        collect(0, got, cycles, bad_hold, timed_out);
        $display("msg time=000102 alarm=0 bytes=%0d cycles=%0d (after reset)", got.size(), cycles);
        checks++;
        if (timed_out || got.size() != exp.size()) begin
            errors++;
            $display("FAIL post_reset_len: timeout=%0d len=%0d, required 0 %0d", timed_out, got.size(), exp.size());
        end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL post_reset_byte%0d: got %02h, required %02h", i, got[i], exp[i]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_stall();
        test_bad_digit();
        test_alarm();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
